// File: rtl/uart_tx_word_fifo_pkg.sv
// rtl/uart_tx_word_fifo_pkg.sv - shared constants and entry type for the UART word feeder
package uart_tx_word_fifo_pkg;

    // Default FIFO depth exponent (16 entries)
    localparam int UTXF_DEPTH_LOG2 = 4;

    // Serialiser state encodings
    localparam logic [1:0] UTXF_IDLE  = 2'd0;
    localparam logic [1:0] UTXF_START = 2'd1;
    localparam logic [1:0] UTXF_HOLD  = 2'd2;
    localparam logic [1:0] UTXF_WAIT  = 2'd3;

    // One queued word: byte count minus one, then the data word
    typedef struct packed {
        logic [1:0]  len;
        logic [31:0] data;
    } utxf_entry_t;

    localparam int UTXF_ENTRY_W = $bits(utxf_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock circular FIFO with count, full, empty and drop indication
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      pop_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  drop_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  wr_en;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] wr_idx;

    assign full_o  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;

    // A flush empties the buffer first, so a push in the same cycle always lands
    assign wr_en  = push_i && (clr_i || !full_o);
    // A pop in the same cycle never makes room for a push against a full buffer
    assign drop_o = push_i && full_o && !clr_i;
    assign rd_en  = pop_i && !empty_o && !clr_i;
    assign wr_idx = clr_i ? '0 : wptr;

    assign pop_data_o = mem[rptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_idx] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr_i) begin
            rptr  <= '0;
            wptr  <= push_i ? DEPTH_LOG2'(1) : '0;
            count <= push_i ? (DEPTH_LOG2 + 1)'(1) : '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_word_fifo.sv
// rtl/uart_tx_word_fifo.sv - buffered word-to-byte feeder for uart_tx
module uart_tx_word_fifo
    import uart_tx_word_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = UTXF_DEPTH_LOG2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                clr_i,
    input  logic                push_i,
    input  logic [31:0]         push_data_i,
    input  logic [1:0]          push_len_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH_LOG2:0] level_o,
    output logic                overflow_o,
    output logic                busy_o,
    output logic                tx_start_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_busy_i
);

    logic [1:0]  state;
    logic [31:0] sh;
    logic [1:0]  rem;
    logic        pop;
    logic        drop;
    utxf_entry_t wr_entry;
    utxf_entry_t head;

    assign wr_entry = {push_len_i, push_data_i};

    // The serialiser only takes a new word while idle; a flush wins over the pop
    assign pop = (state == UTXF_IDLE) && !empty_o && !clr_i;

    sync_fifo #(
        .WIDTH      (UTXF_ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clr_i       (clr_i),
        .push_i      (push_i),
        .push_data_i (wr_entry),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (level_o),
        .drop_o      (drop)
    );

    assign tx_start_o = (state == UTXF_START) && !clr_i;
    assign tx_data_o  = sh[7:0];
    assign busy_o     = !empty_o || (state != UTXF_IDLE) || tx_start_o || tx_busy_i;

    // Serialiser: pop a word, then strobe each byte LSB first, waiting out uart_tx busy
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= UTXF_IDLE;
            sh    <= '0;
            rem   <= '0;
        end else if (clr_i) begin
            state <= UTXF_IDLE;
            sh    <= '0;
            rem   <= '0;
        end else begin
            case (state)
                UTXF_IDLE: begin
                    if (!empty_o) begin
                        sh    <= head.data;
                        rem   <= head.len;
                        state <= UTXF_START;
                    end
                end
                UTXF_START: begin
                    state <= UTXF_HOLD;
                end
                UTXF_HOLD: begin
                    // uart_tx raises busy a cycle after the strobe, so skip one sample
                    state <= UTXF_WAIT;
                end
                UTXF_WAIT: begin
                    if (!tx_busy_i) begin
                        if (rem == 2'd0) begin
                            state <= UTXF_IDLE;
                        end else begin
                            sh    <= sh >> 8;
                            rem   <= rem - 1'b1;
                            state <= UTXF_START;
                        end
                    end
                end
                default: begin
                    state <= UTXF_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: set by a dropped push, cleared only by flush or reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overflow_o <= 1'b0;
        end else if (clr_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_word_fifo.sv
// tb/tb_uart_tx_word_fifo.sv - directed self-checking bench for uart_tx_word_fifo
module tb_uart_tx_word_fifo;

    localparam int DL2      = 2;
    localparam int BYTE_CYC = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clr;
    logic          push;
    logic [31:0]   pdata;
    logic [1:0]    plen;
    logic          full;
    logic          empty;
    logic [DL2:0]  level;
    logic          overflow;
    logic          busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic          stall;

    int            busy_cnt = 0;
    int            cyc = 0;
    int            b2b = 0;
    logic          prev_start = 1'b0;
    int            errors = 0;
    int            checks = 0;
    logic [7:0]    seen[$];
    int            seen_cyc[$];

    uart_tx_word_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .clr_i       (clr),
        .push_i      (push),
        .push_data_i (pdata),
        .push_len_i  (plen),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level),
        .overflow_o  (overflow),
        .busy_o      (busy),
        .tx_start_o  (tx_start),
        .tx_data_o   (tx_data),
        .tx_busy_i   (tx_busy)
    );

    always #5 clk = ~clk;

    assign tx_busy = stall || (busy_cnt > 0);

    always @(posedge clk) cyc++;

    // uart_tx stand-in: logs each strobed byte and stays busy for BYTE_CYC cycles
    always @(negedge clk) begin
        if (tx_start) begin
            seen.push_back(tx_data);
            seen_cyc.push_back(cyc);
            busy_cnt = BYTE_CYC;
            if (prev_start) b2b++;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        prev_start = tx_start;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic [1:0] l);
        push  = 1'b1;
        pdata = d;
        plen  = l;
        @(posedge clk);
        #1 push = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        @(negedge clk); #2;
        while (busy && n < max) begin
            @(negedge clk); #2;
            n++;
        end
        check({tag, "_idle"}, busy, 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] byte_at(input int idx);
        if (idx < seen.size()) return {8'h00, seen[idx]};
        return 16'hFFFF;
    endfunction

    function automatic int gap_at(input int idx);
        if (idx + 1 < seen_cyc.size()) return seen_cyc[idx + 1] - seen_cyc[idx];
        return -1;
    endfunction

    task automatic run_basic(input string tag);
        int base = seen.size();
        logic [31:0] w = '0;
        push_word(32'h44434241, 2'd3);
        @(negedge clk);
        check({tag, "_n1_start"}, tx_start, 0);
        check({tag, "_n1_empty"}, empty, 0);
        check({tag, "_n1_level"}, level, 1);
        @(negedge clk);
        check({tag, "_n2_start"}, tx_start, 1);
        check({tag, "_n2_data"}, tx_data, 8'h41);
        wait_idle(tag, 200);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = byte_at(base + i)[7:0];
        check({tag, "_nbytes"}, seen.size() - base, 4);
        check({tag, "_bytes"}, w, 32'h44434241);
        check({tag, "_gap"}, gap_at(base), 4);
    endtask

    logic [7:0] exp3 [11] = '{8'h11, 8'h21, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                              8'h66, 8'h77, 8'h88, 8'h99};

    initial begin
        int base;
        int n;
        int n_bad;

        rstn = 1'b0; clr = 1'b0; push = 1'b0; pdata = '0; plen = '0; stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // single four-byte word
        run_basic("s1");

        // short words back to back
        base = seen.size();
        push_word(32'h000000AA, 2'd0);
        push_word(32'h0000BBCC, 2'd1);
        wait_idle("s2", 200);
        check("s2_nbytes", seen.size() - base, 3);
        check("s2_bytes", {byte_at(base + 2)[7:0], byte_at(base + 1)[7:0], byte_at(base)[7:0]}, 24'hBBCCAA);
        check("s2_gap_word", gap_at(base), 5);
        check("s2_gap_byte", gap_at(base + 1), 4);
        check("s2_empty", empty, 1);

        // fill while stalled, overflow, then push during the pop cycle
        base = seen.size();
        stall = 1'b1;
        push_word(32'h00000011, 2'd0);
        push_word(32'h00002221, 2'd1);
        push_word(32'h00000033, 2'd0);
        push_word(32'h00665544, 2'd2);
        push_word(32'h99887766, 2'd3);
        push_word(32'h000000EE, 2'd0);
        @(negedge clk);
        check("s3_level", level, 4);
        check("s3_full", full, 1);
        check("s3_ovf", overflow, 1);
        @(posedge clk); #1 stall = 1'b0;
        @(posedge clk); #1;
        push_word(32'h000000F0, 2'd0);
        @(negedge clk);
        check("s4_level", level, 3);
        check("s4_full", full, 0);
        check("s4_ovf", overflow, 1);
        @(posedge clk); #1;
        wait_idle("s3", 600);
        check("s3_nbytes", seen.size() - base, 11);
        for (int i = 0; i < 11; i++) check("s3_byte", byte_at(base + i), {8'h00, exp3[i]});

        // flush in the middle of a word
        base = seen.size();
        push_word(32'h44434241, 2'd3);
        push_word(32'h00000055, 2'd0);
        n = 0;
        while (seen.size() < base + 2 && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        check("s5_second_start", seen.size() - base, 2);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk); #2;
        check("s5_level", level, 0);
        check("s5_empty", empty, 1);
        check("s5_ovf", overflow, 0);
        check("s5_busy_held", busy, 1);
        n_bad = 0;
        n = 0;
        while (tx_busy && n < 20) begin
            @(negedge clk); #2;
            if (busy !== tx_busy) n_bad++;
            n++;
        end
        check("s5_busy_track", n_bad, 0);
        check("s5_busy_end", busy, 0);
        repeat (10) @(posedge clk);
        #1;
        check("s5_nbytes", seen.size() - base, 2);
        check("s5_bytes", {byte_at(base + 1)[7:0], byte_at(base)[7:0]}, 16'h4241);

        // asynchronous reset while waiting on uart_tx
        base = seen.size();
        push_word(32'h01020304, 2'd3);
        push_word(32'h00000077, 2'd0);
        n = 0;
        while (seen.size() < base + 1 && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        check("s6_first_start", seen.size() - base, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("s6_start", tx_start, 0);
        check("s6_data", tx_data, 0);
        check("s6_level", level, 0);
        check("s6_empty", empty, 1);
        check("s6_full", full, 0);
        check("s6_ovf", overflow, 0);
        repeat (6) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("s6_busy_after", busy, 0);
        @(posedge clk); #1;
        run_basic("s6b");

        check("no_b2b_start", b2b, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
